// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a fixed-read-latency FIFO and presents the words as an AXI-Stream master.
// Defining FIFO_READER_LAST_EN adds m_axis_tlast_o, asserted on every PKT_LEN-th beat.
module fifo_stream_reader #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int PKT_LEN      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_pop_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i
`ifdef FIFO_READER_LAST_EN
  ,
  output logic                  m_axis_tlast_o
`endif
);

  localparam int DEPTH = READ_LATENCY + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("fifo_stream_reader: READ_LATENCY must be in 1..4");
  end
  if (PKT_LEN < 1) begin : g_bad_pkt_len
    $error("fifo_stream_reader: PKT_LEN must be at least 1");
  end

  // Handshake: a beat moves when m_axis_tvalid_o && m_axis_tready_i are both high in
  // one cycle; once tvalid is up, tvalid and tdata stay frozen until that beat moves.

  logic [CNT_W-1:0]        credit_q;
  logic [CNT_W-1:0]        credit_d;
  logic [CNT_W-1:0]        buf_count_q;
  logic [CNT_W-1:0]        buf_count_d;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [READ_LATENCY-1:0] inflight_q;
  logic [DATA_WIDTH-1:0]   buf_q [DEPTH];
  logic                    transfer;
  logic                    buf_wr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign transfer        = m_axis_tvalid_o && m_axis_tready_i;
  assign buf_wr          = inflight_q[READ_LATENCY-1];
  assign m_axis_tvalid_o = (buf_count_q != '0);
  assign m_axis_tdata_o  = m_axis_tvalid_o ? buf_q[rd_ptr_q] : '0;

  // Credits count both buffered words and words still in the FIFO read pipe, so a
  // pop is only issued when its word is guaranteed a buffer slot on arrival.
  always_comb begin
    fifo_pop_o = 1'b0;
    if (!rst_i && !fifo_empty_i && ((credit_q < DEPTH_C) || transfer)) begin
      fifo_pop_o = 1'b1;
    end
  end

  always_comb begin
    credit_d = credit_q;
    if (fifo_pop_o && !transfer) begin
      credit_d = credit_q + CNT_W'(1);
    end else if (!fifo_pop_o && transfer) begin
      credit_d = credit_q - CNT_W'(1);
    end
  end

  always_comb begin
    buf_count_d = buf_count_q;
    if (buf_wr && !transfer) begin
      buf_count_d = buf_count_q + CNT_W'(1);
    end else if (!buf_wr && transfer) begin
      buf_count_d = buf_count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credit_q    <= '0;
      buf_count_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      inflight_q  <= '0;
    end else begin
      credit_q    <= credit_d;
      buf_count_q <= buf_count_d;
      inflight_q  <= (inflight_q << 1) | READ_LATENCY'(fifo_pop_o);
      if (buf_wr) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (transfer) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  // Storage needs no reset: contents are only visible while buf_count_q is non-zero.
  always_ff @(posedge clk_i) begin
    if (buf_wr) begin
      buf_q[wr_ptr_q] <= fifo_data_i;
    end
  end

`ifdef FIFO_READER_LAST_EN
  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

  logic [BEAT_W-1:0] beat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_q <= '0;
    end else if (transfer) begin
      beat_q <= (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
    end
  end

  assign m_axis_tlast_o = m_axis_tvalid_o && (beat_q == BEAT_LAST);
`endif

endmodule
